// File: rtl/slc3_mem_responder_pkg.sv
// Shared types and default I/O addresses for the SLC-3 memory responder.
package slc3_mem_pkg;

    typedef logic [15:0] word_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_WAIT = 3'd1,
        RD_HOLD = 3'd2,
        WR_WAIT = 3'd3,
        WR_HOLD = 3'd4
    } mem_state_t;

    localparam logic [15:0] IO_SW_ADDR_DFLT  = 16'hFFFF;
    localparam logic [15:0] IO_HEX_ADDR_DFLT = 16'hFFFF;

endpackage

// File: rtl/slc3_mem_responder_if.sv
// Controller <-> memory strobe bus: address, write data, OE/WE strobes and the read/write status returned.
interface slc3_mem_responder_if #(
    parameter int ADDR_W = 16
);
    import slc3_mem_pkg::*;

    logic [ADDR_W-1:0] MAR;
    word_t             MDR_out;
    logic              Mem_OE;
    logic              Mem_WE;
    word_t             Data_to_CPU;
    logic              Rd_valid;
    logic              Wr_done;

    modport master (
        output MAR, MDR_out, Mem_OE, Mem_WE,
        input  Data_to_CPU, Rd_valid, Wr_done
    );

    modport slave (
        input  MAR, MDR_out, Mem_OE, Mem_WE,
        output Data_to_CPU, Rd_valid, Wr_done
    );

endinterface

// File: rtl/slc3_mem_responder_sync_ram.sv
// Single-port word RAM: synchronous write, asynchronous read, no reset on contents.
module slc3_sync_ram
    import slc3_mem_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic [DEPTH_LOG2-1:0] i_addr,
    input  word_t                 i_wdata,
    output word_t                 o_rdata
);

    word_t r_mem [2**DEPTH_LOG2];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/slc3_mem_responder.sv
// SLC-3 memory-side responder: services Mem_OE/Mem_WE strobes against on-chip RAM plus switch/hex I/O.
// Optional sticky Abort_flag output is built when SLC3_MEM_ABORT_FLAG_EN is defined.
module slc3_mem_responder
    import slc3_mem_pkg::*;
#(
    parameter int                ADDR_W      = 16,
    parameter int                DEPTH_LOG2  = 10,
    parameter int                READ_LAT    = 3,
    parameter int                WRITE_LAT   = 2,
    parameter logic [ADDR_W-1:0] IO_SW_ADDR  = IO_SW_ADDR_DFLT,
    parameter logic [ADDR_W-1:0] IO_HEX_ADDR = IO_HEX_ADDR_DFLT
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    slc3_mem_responder_if.slave  bus,
    input  word_t                SW,
    output word_t                HEX_reg
`ifdef SLC3_MEM_ABORT_FLAG_EN
    ,
    output logic                 Abort_flag
`endif
);

    localparam logic [2:0] RD_LAT_C = 3'(READ_LAT);
    localparam logic [2:0] WR_LAT_C = 3'(WRITE_LAT);

    mem_state_t        r_state;
    mem_state_t        w_state_next;
    logic [2:0]        r_cnt;
    logic [2:0]        w_cnt_next;
    logic [ADDR_W-1:0] r_addr;
    word_t             r_wdata;
    word_t             r_rdata;
    logic              r_rd_valid;
    logic              r_wr_done;
    word_t             r_hex;

    logic              w_latch_rd;
    logic              w_latch_wr;
    logic              w_load_rd;
    logic              w_rd_drop;
    logic              w_commit;
    logic              w_abort;
    logic              w_is_hex;
    logic              w_ram_we;
    word_t             w_ram_rdata;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_latch_rd   = 1'b0;
        w_latch_wr   = 1'b0;
        w_load_rd    = 1'b0;
        w_rd_drop    = 1'b0;
        w_commit     = 1'b0;
        w_abort      = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.Mem_OE) begin
                    w_cnt_next = 3'd1;
                    if (bus.Mem_WE) begin
                        w_latch_wr   = 1'b1;
                        w_state_next = WR_WAIT;
                    end else begin
                        w_latch_rd   = 1'b1;
                        w_state_next = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                // WE is deliberately not looked at: a read in flight always completes as a read.
                if (!bus.Mem_OE) begin
                    w_abort      = 1'b1;
                    w_state_next = IDLE;
                end else if (r_cnt == RD_LAT_C) begin
                    w_load_rd    = 1'b1;
                    w_state_next = RD_HOLD;
                end else begin
                    w_cnt_next = r_cnt + 3'd1;
                end
            end
            RD_HOLD: begin
                if (!bus.Mem_OE) begin
                    w_rd_drop    = 1'b1;
                    w_state_next = IDLE;
                end
            end
            WR_WAIT: begin
                if (!bus.Mem_OE) begin
                    w_abort      = 1'b1;
                    w_state_next = IDLE;
                end else if (r_cnt == WR_LAT_C) begin
                    w_commit     = 1'b1;
                    w_state_next = WR_HOLD;
                end else begin
                    w_cnt_next = r_cnt + 3'd1;
                end
            end
            WR_HOLD: begin
                if (!bus.Mem_OE || !bus.Mem_WE) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign w_is_hex = (r_addr == IO_HEX_ADDR);
    // Gate with reset so an access abandoned by reset can never land in RAM.
    assign w_ram_we = w_commit && !w_is_hex && Reset_n;

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_state    <= IDLE;
            r_cnt      <= 3'd0;
            r_rdata    <= '0;
            r_rd_valid <= 1'b0;
            r_wr_done  <= 1'b0;
            r_hex      <= '0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_wr_done <= w_commit;
            if (w_load_rd) begin
                r_rdata    <= (r_addr == IO_SW_ADDR) ? SW : w_ram_rdata;
                r_rd_valid <= 1'b1;
            end else if (w_rd_drop) begin
                r_rd_valid <= 1'b0;
            end
            if (w_commit && w_is_hex) begin
                r_hex <= r_wdata;
            end
        end
    end

    // Address/data capture needs no reset: they are only consumed after a fresh latch.
    always_ff @(posedge Clk) begin
        if (w_latch_rd || w_latch_wr) begin
            r_addr <= bus.MAR;
        end
        if (w_latch_wr) begin
            r_wdata <= bus.MDR_out;
        end
    end

`ifdef SLC3_MEM_ABORT_FLAG_EN
    logic r_abort;

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_abort <= 1'b0;
        end else if (w_abort) begin
            r_abort <= 1'b1;
        end
    end

    assign Abort_flag = r_abort;
`else
    logic w_abort_unused;
    assign w_abort_unused = w_abort;
`endif

    slc3_sync_ram #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ram (
        .i_clk   (Clk),
        .i_we    (w_ram_we),
        .i_addr  (r_addr[DEPTH_LOG2-1:0]),
        .i_wdata (r_wdata),
        .o_rdata (w_ram_rdata)
    );

    assign bus.Data_to_CPU = r_rdata;
    assign bus.Rd_valid    = r_rd_valid;
    assign bus.Wr_done     = r_wr_done;
    assign HEX_reg         = r_hex;

endmodule

// File: tb/tb_slc3_mem_responder.sv
// Randomized strobe traffic against a transaction-level model of the responder, plus directed pins.
module tb_slc3_mem_responder;
    import slc3_mem_pkg::*;

    localparam int          RL      = 3;
    localparam int          WL      = 2;
    localparam logic [15:0] IO_ADDR = 16'hFFFF;

    logic  clk = 1'b0;
    logic  rst_n;
    word_t sw;
    word_t hex;
`ifdef SLC3_MEM_ABORT_FLAG_EN
    logic  abort_flag;
`endif

    always #5 clk = ~clk;

    slc3_mem_responder_if #(.ADDR_W(16)) bus ();

    slc3_mem_responder #(
        .ADDR_W      (16),
        .DEPTH_LOG2  (10),
        .READ_LAT    (RL),
        .WRITE_LAT   (WL),
        .IO_SW_ADDR  (IO_ADDR),
        .IO_HEX_ADDR (IO_ADDR)
    ) dut (
        .Clk        (clk),
        .Reset_n    (rst_n),
        .bus        (bus),
        .SW         (sw),
        .HEX_reg    (hex)
`ifdef SLC3_MEM_ABORT_FLAG_EN
        ,
        .Abort_flag (abort_flag)
`endif
    );

    // Model state: RAM image, expected outputs after the next rising edge.
    word_t mem_m [1024];
    word_t exp_data;
    logic  exp_rv;
    logic  exp_wd;
    word_t exp_hex;
    logic  exp_abort;
    bit    check_en  = 0;
    bit    quiet     = 0;
    bit    sw_rand   = 1;
    bit    late_zero = 0;
    int    n_cmp     = 0;
    int    n_bad     = 0;
    int    wd_seen   = 0;
    int    xfer_no   = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (bus.Wr_done === 1'b1) wd_seen++;
        if (check_en) begin
            chk("Data_to_CPU", bus.Data_to_CPU, exp_data);
            chk("Rd_valid", 16'(bus.Rd_valid), 16'(exp_rv));
            chk("Wr_done", 16'(bus.Wr_done), 16'(exp_wd));
            chk("HEX_reg", hex, exp_hex);
`ifdef SLC3_MEM_ABORT_FLAG_EN
            chk("Abort_flag", 16'(abort_flag), 16'(exp_abort));
`endif
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.Mem_OE  = 1'b0;
            bus.Mem_WE  = 1'($urandom_range(0, 1));
            bus.MAR     = 16'($urandom);
            bus.MDR_out = 16'($urandom);
            if (sw_rand) sw = 16'($urandom);
            exp_wd = 1'b0;
        end
    endtask

    // One strobe: OE held for 'hold' edges starting at edge 1, then dropped.
    // Reads load at edge RL+1 and writes commit at edge WL+1, if the strobe is still up.
    task automatic xfer(input bit is_wr, input logic [15:0] addr, input word_t data,
                        input int hold, input int glitch_at, input int rst_at);
        int lat;
        bit reset_hit;
        lat       = is_wr ? WL : RL;
        reset_hit = 1'b0;
        for (int i = 1; i <= hold && !reset_hit; i++) begin
            @(negedge clk);
            bus.MAR     = (i == 1) ? addr : 16'($urandom);
            bus.MDR_out = (i == 1) ? data : (late_zero ? 16'h0000 : 16'($urandom));
            if (sw_rand) sw = 16'($urandom);
            if (i == rst_at) begin
                rst_n      = 1'b0;
                bus.Mem_OE = 1'b0;
                bus.Mem_WE = 1'b0;
                exp_data   = '0;
                exp_rv     = 1'b0;
                exp_wd     = 1'b0;
                exp_hex    = '0;
                exp_abort  = 1'b0;
                reset_hit  = 1'b1;
            end else begin
                bus.Mem_OE = 1'b1;
                bus.Mem_WE = is_wr || (glitch_at > 0 && i >= glitch_at);
                exp_wd     = 1'b0;
                if (i == lat + 1) begin
                    if (is_wr) begin
                        exp_wd = 1'b1;
                        if (addr == IO_ADDR) exp_hex = data;
                        else mem_m[addr[9:0]] = data;
                    end else begin
                        exp_data = (addr == IO_ADDR) ? sw : mem_m[addr[9:0]];
                        exp_rv   = 1'b1;
                    end
                end
            end
        end
        @(negedge clk);
        rst_n       = 1'b1;
        bus.Mem_OE  = 1'b0;
        bus.Mem_WE  = 1'($urandom_range(0, 1));
        bus.MAR     = 16'($urandom);
        bus.MDR_out = 16'($urandom);
        if (sw_rand) sw = 16'($urandom);
        exp_rv = 1'b0;
        exp_wd = 1'b0;
        if (!reset_hit && hold < lat + 1) exp_abort = 1'b1;
        xfer_no++;
        if (!quiet)
            $display("xfer %0d: %s addr=%h data=%h hold=%0d glitch=%0d rst=%0d abort_model=%0b",
                     xfer_no, is_wr ? "WR" : "RD", addr, data, hold, glitch_at, rst_at, exp_abort);
    endtask

    // Let the drop edge of the last strobe pass, then sample its outputs.
    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    int base;

    initial begin
        rst_n       = 1'b0;
        bus.Mem_OE  = 1'b0;
        bus.Mem_WE  = 1'b0;
        bus.MAR     = '0;
        bus.MDR_out = '0;
        sw          = '0;
        exp_data    = '0;
        exp_rv      = 1'b0;
        exp_wd      = 1'b0;
        exp_hex     = '0;
        exp_abort   = 1'b0;

        @(negedge clk);
        check_en = 1;
        idle(2);
        @(negedge clk);
        rst_n = 1'b1;

        // Give every RAM word a known value so all later reads are predictable.
        quiet = 1;
        for (int a = 0; a < 1024; a++) begin
            xfer(1'b1, 16'(a), 16'($urandom), WL + 1, 0, 0);
        end
        quiet = 0;

        // Read timing.
        xfer(1'b1, 16'h0010, 16'h1234, 3, 0, 0);
        xfer(1'b0, 16'h0010, 16'h0000, 5, 0, 0);
        settle();
        chk("read_0010_data", bus.Data_to_CPU, 16'h1234);
        chk("read_0010_rv_after_drop", 16'(bus.Rd_valid), 16'h0000);

        // Single commit with MDR_out changing after the first strobe cycle.
        base      = wd_seen;
        late_zero = 1;
        xfer(1'b1, 16'h0020, 16'hBEEF, 4, 0, 0);
        late_zero = 0;
        settle();
        chk("write_0020_pulses", 16'(wd_seen - base), 16'd1);
        xfer(1'b0, 16'h0020, 16'h0000, 4, 0, 0);
        settle();
        chk("read_0020_data", bus.Data_to_CPU, 16'hBEEF);

        // Memory-mapped I/O.
        sw_rand = 0;
        sw      = 16'hA5A5;
        xfer(1'b0, 16'hFFFF, 16'h0000, 4, 0, 0);
        settle();
        chk("read_sw", bus.Data_to_CPU, 16'hA5A5);
        sw_rand = 1;
        xfer(1'b1, 16'h03FF, 16'h3FF3, 3, 0, 0);
        xfer(1'b1, 16'hFFFF, 16'h0042, 3, 0, 0);
        settle();
        chk("hex_write", hex, 16'h0042);
        xfer(1'b0, 16'h03FF, 16'h0000, 4, 0, 0);
        settle();
        chk("ram_3ff_untouched", bus.Data_to_CPU, 16'h3FF3);

        // Abort after one strobe cycle.
        xfer(1'b1, 16'h0030, 16'h5555, 3, 0, 0);
        base = wd_seen;
        xfer(1'b1, 16'h0030, 16'h9999, 1, 0, 0);
        settle();
        chk("abort_pulses", 16'(wd_seen - base), 16'd0);
`ifdef SLC3_MEM_ABORT_FLAG_EN
        chk("abort_flag_set", 16'(abort_flag), 16'd1);
`endif
        xfer(1'b0, 16'h0030, 16'h0000, 4, 0, 0);
        settle();
        chk("abort_ram_kept", bus.Data_to_CPU, 16'h5555);

        // Address wrap.
        xfer(1'b1, 16'h0405, 16'h7777, 3, 0, 0);
        xfer(1'b0, 16'h0005, 16'h0000, 4, 0, 0);
        settle();
        chk("wrap_read", bus.Data_to_CPU, 16'h7777);

        // Reset during RD_WAIT.
        xfer(1'b0, 16'h0010, 16'h0000, 5, 0, 2);
        settle();
        chk("rst_data", bus.Data_to_CPU, 16'h0000);
        chk("rst_rv", 16'(bus.Rd_valid), 16'h0000);
        chk("rst_hex", hex, 16'h0000);

        // Reset landing on the commit edge must not write.
        xfer(1'b1, 16'h0040, 16'h1111, 3, 0, 0);
        xfer(1'b1, 16'h0040, 16'h2222, 4, 0, WL + 1);
        xfer(1'b0, 16'h0040, 16'h0000, 4, 0, 0);
        settle();
        chk("rst_no_commit", bus.Data_to_CPU, 16'h1111);

        // Random traffic: aborts, holds, WE glitches during reads, I/O hits, gaps.
        for (int t = 0; t < 300; t++) begin
            bit          is_wr;
            logic [15:0] addr;
            int          hold;
            int          glitch;
            is_wr  = 1'($urandom_range(0, 1));
            addr   = ($urandom_range(0, 7) == 0) ? IO_ADDR : 16'($urandom);
            hold   = $urandom_range(1, 7);
            glitch = (!is_wr && $urandom_range(0, 3) == 0) ? $urandom_range(2, hold + 1) : 0;
            xfer(is_wr, addr, 16'($urandom), hold, glitch, 0);
            idle($urandom_range(0, 2));
        end

        idle(2);
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
